muldiv_sequencer: RTL and testbench

//  Iterative unsigned multiply/divide sequencer with HI/LO result registers for the 5-stage pipeline.

---
 rtl/muldiv_sequencer.sv | 142 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU sequencer with HI/LO result registers.
// One result bit per cycle; Stall holds the pipeline while an operation is in flight.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HLRead,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem_nx;
    logic [WIDTH-1:0]   div_quo_nx;

    // Start is a request strobe taken only in IDLE/DONE; while Busy it is
    // ignored and the pipeline keeps re-presenting it under Stall.
    assign Busy      = (state == MUL) || (state == DIV);
    assign Done      = (state == DONE);
    assign Stall     = Busy & (Start | HLRead);
    assign dbg_state = state;

    // Multiply: prod = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign mul_add = prod[0] ? opnd : '0;
    assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign mul_nx  = {mul_sum, prod[WIDTH-1:1]};

    // Divide: prod[WIDTH-1:0] shifts dividend out and quotient in; trial sign decides restore.
    assign div_shift  = {rem, prod[WIDTH-1]};
    assign div_trial  = div_shift - {1'b0, opnd};
    assign div_ge     = ~div_trial[WIDTH];
    assign div_rem_nx = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo_nx = {prod[WIDTH-2:0], div_ge};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (Start) begin
                    case (Op)
                        2'b00:   state_nx = MUL;
                        2'b01:   state_nx = (SrcB == '0) ? DONE : DIV;
                        default: state_nx = IDLE;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == '0)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            cnt     <= '0;
            opnd    <= '0;
            prod    <= '0;
            rem     <= '0;
            HI      <= '0;
            LO      <= '0;
            DivZero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        DivZero <= 1'b0;
                        case (Op)
                            2'b00: begin
                                opnd <= SrcA;
                                prod <= {{WIDTH{1'b0}}, SrcB};
                                cnt  <= CW'(WIDTH - 1);
                            end
                            2'b01: begin
                                if (SrcB == '0) begin
                                    HI      <= SrcA;
                                    LO      <= '1;
                                    DivZero <= 1'b1;
                                end else begin
                                    opnd <= SrcB;
                                    prod <= {{WIDTH{1'b0}}, SrcA};
                                    rem  <= '0;
                                    cnt  <= CW'(WIDTH - 1);
                                end
                            end
                            2'b10:   HI <= SrcA;
                            default: LO <= SrcA;
                        endcase
                    end
                end
                MUL: begin
                    prod <= mul_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        HI <= mul_nx[2*WIDTH-1:WIDTH];
                        LO <= mul_nx[WIDTH-1:0];
                    end
                end
                DIV: begin
                    prod[WIDTH-1:0] <= div_quo_nx;
                    rem             <= div_rem_nx;
                    cnt             <= cnt - 1'b1;
                    if (cnt == '0) begin
                        HI <= div_rem_nx;
                        LO <= div_quo_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomised scoreboard bench for muldiv_sequencer: driver pushes expected
// HI/LO/DivZero from an arithmetic model, a negedge monitor pops on Done.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         HLRead = 1'b0;
    logic         Busy, Done, Stall, DivZero;
    logic [W-1:0] HI, LO;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*W:0] exp_q[$];
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .HLRead(HLRead), .Busy(Busy), .Done(Done), .Stall(Stall), .DivZero(DivZero),
        .HI(HI), .LO(LO), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: every Done pulse must match the oldest expected result
    always @(negedge CLK) begin
        if (!RST && Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: Done=1 with no result pending (t=%0t)", $time);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                chk("result_hi", HI, e[2*W-1:W]);
                chk("result_lo", LO, e[W-1:0]);
                chk("result_divzero", DivZero, e[2*W]);
                chk("done_not_busy", Busy, 0);
            end
        end
    end

    // reference model: plain arithmetic on the accepted request
    task automatic model_accept(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        case (op)
            2'b00: begin
                p = 64'(a) * 64'(b);
                model_hi = p[2*W-1:W];
                model_lo = p[W-1:0];
                exp_q.push_back({1'b0, model_hi, model_lo});
            end
            2'b01: begin
                if (b == 0) begin
                    model_hi = a;
                    model_lo = '1;
                    exp_q.push_back({1'b1, model_hi, model_lo});
                end else begin
                    model_hi = a % b;
                    model_lo = a / b;
                    exp_q.push_back({1'b0, model_hi, model_lo});
                end
            end
            2'b10:   model_hi = a;
            default: model_lo = a;
        endcase
    endtask

    // driver: present a request for one edge; returns at the negedge after acceptance
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge CLK);
        model_accept(op, a, b);
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cycles, input int exp_busy);
        int n;
        int nb;
        n  = 1;
        nb = 0;
        while (!Done && n <= 200) begin
            if (Busy) nb++;
            @(negedge CLK);
            n++;
        end
        chk("done_latency", n, exp_cycles);
        chk("busy_cycles", nb, exp_busy);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        issue(op, a, b);
        if (op == 2'b00 || (op == 2'b01 && b != 0)) begin
            wait_done(W + 1, W);
        end else if (op == 2'b01) begin
            wait_done(1, 0);
        end else begin
            chk("mthlo_hi", HI, model_hi);
            chk("mthlo_lo", LO, model_lo);
            chk("mthlo_no_done", Done, 0);
            chk("mthlo_no_busy", Busy, 0);
            chk("mthlo_divzero_clr", DivZero, 0);
        end
    endtask

    initial begin
        logic [W-1:0] a, b, c, d, old_hi, old_lo;
        int n;

        // reset
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("reset_hi", HI, 0);
        chk("reset_lo", LO, 0);
        chk("reset_busy", Busy, 0);
        chk("reset_done", Done, 0);
        chk("reset_divzero", DivZero, 0);
        chk("reset_stall", Stall, 0);
        chk("reset_state", dbg_state, 0);

        // directed corner cases
        run_op(2'b00, 32'd7, 32'd6);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b01, 32'd100, 32'd7);
        run_op(2'b01, 32'd5, 32'd0);
        repeat (3) @(negedge CLK);
        chk("divzero_held", DivZero, 1);
        HLRead = 1'b1;
        #1;
        chk("stall_idle_read", Stall, 0);
        HLRead = 1'b0;
        run_op(2'b10, 32'hDEAD_BEEF, 32'd0);
        run_op(2'b01, 32'd3, 32'd10);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1);

        // randomised traffic
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            run_op(2'($urandom_range(0, 3)), a, b);
        end

        // stall while MULTU in flight, DIVU held until the DONE cycle
        a = $urandom;
        b = $urandom;
        c = $urandom;
        d = $urandom | 32'h100;
        old_hi = model_hi;
        old_lo = model_lo;
        issue(2'b00, a, b);
        Start  = 1'b1;
        Op     = 2'b01;
        SrcA   = c;
        SrcB   = d;
        HLRead = 1'b1;
        n = 1;
        while (!Done && n <= 200) begin
            #1;
            chk("stall_busy", Stall, 1);
            chk("hold_hi", HI, old_hi);
            chk("hold_lo", LO, old_lo);
            @(negedge CLK);
            n++;
        end
        chk("stall_done_latency", n, W + 1);
        #1;
        chk("stall_drops_in_done", Stall, 0);
        @(posedge CLK);
        model_accept(2'b01, c, d);
        @(negedge CLK);
        Start  = 1'b0;
        HLRead = 1'b0;
        chk("b2b_busy", Busy, 1);
        #1;
        chk("no_stall_quiet", Stall, 0);
        wait_done(W + 1, W);

        // reset mid-operation
        issue(2'b00, $urandom, $urandom);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        chk("abort_state", dbg_state, 0);
        repeat (40) @(negedge CLK);
        run_op(2'b11, 32'h1234, 32'd0);
        chk("mtlo_after_reset", LO, 32'h1234);

        repeat (3) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
